// File: rtl/shift_pkg.sv
// Shared constants, op encodings, FSM states and the one-bit shift step
// used by the multi-cycle shift unit.
package shift_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_SLL  = 3'd0;
  localparam logic [OP_W-1:0] OP_SRL  = 3'd1;
  localparam logic [OP_W-1:0] OP_SRA  = 3'd2;
  localparam logic [OP_W-1:0] OP_SLLV = 3'd3;
  localparam logic [OP_W-1:0] OP_SRLV = 3'd4;
  localparam logic [OP_W-1:0] OP_SRAV = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One shift step; arithmetic right re-samples the current sign bit.
  function automatic logic [DATA_W-1:0] shift_one(input logic [OP_W-1:0] op,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (op)
      OP_SLL, OP_SLLV: r = {d[DATA_W-2:0], 1'b0};
      OP_SRL, OP_SRLV: r = {1'b0, d[DATA_W-1:1]};
      OP_SRA, OP_SRAV: r = {d[DATA_W-1], d[DATA_W-1:1]};
      default:         r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the control FSM (master) and the shift
// unit (slave): start/op/shamt/rs/rt in, busy/done/result out.
interface shift_sequencer_if;
  logic                             start;
  logic [shift_pkg::OP_W-1:0]       op;
  logic [shift_pkg::AMT_W-1:0]      shamt;
  logic [shift_pkg::DATA_W-1:0]     rs;
  logic [shift_pkg::DATA_W-1:0]     rt;
  logic                             busy;
  logic                             done;
  logic [shift_pkg::DATA_W-1:0]     result;

  modport master (output start, op, shamt, rs, rt, input busy, done, result);
  modport slave  (input start, op, shamt, rs, rt, output busy, done, result);
endinterface

// File: rtl/shift_sequencer_shamt_select.sv
// Shift-amount mux: shamt for immediate ops, rs[4:0] for variable ops,
// zero-extended to the counter width; reserved ops yield 0.
// Ports: op, shamt, rs_lo (rs[4:0]) in; amt_c (combinational) out.
module shamt_select
  import shift_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [AMT_W-1:0]  rs_lo,
  output logic [DATA_W-1:0] amt_c
);

  always_comb begin
    amt_c = '0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA:    amt_c = DATA_W'(shamt);
      OP_SLLV, OP_SRLV, OP_SRAV: amt_c = DATA_W'(rs_lo);
      default:                   amt_c = '0;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter for sll/srl/sra/sllv/srlv/srav: one bit per clock.
// Ports: clk, rst (async, active-high), bus (slave modport: start/op/shamt/
// rs/rt in; busy/done/result out, all registered).
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] amt_c;
  logic              unused_rs_hi_c;

  // Only rs[4:0] carries the variable amount.
  assign unused_rs_hi_c = ^bus.rs[DATA_W-1:AMT_W];

  shamt_select u_shamt_select (
    .op    (bus.op),
    .shamt (bus.shamt),
    .rs_lo (bus.rs[AMT_W-1:0]),
    .amt_c (amt_c)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          data_d  = bus.rt;
          op_d    = bus.op;
          cnt_d   = amt_c;
          state_d = (amt_c == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = shift_one(op_q, data_q);
        cnt_d  = cnt_q - DATA_W'(1);
        if (cnt_q == DATA_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Result captures the data register value on entry to DONE.
    if (state_d == DONE) result_d = data_d;
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver pushes expected result and
// timing from a plain-arithmetic model; a monitor checks busy/done/result.
module tb_shift_sequencer;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_result = 32'h0;
  exp_t sb[$];

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: amount selection and whole-word shift in one step.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [4:0] sh,
                                            input logic [31:0] rs, input logic [31:0] rt,
                                            output int n);
    logic [4:0] rs_amt;
    rs_amt = rs[4:0];
    case (op)
      3'd0, 3'd1, 3'd2: n = int'(sh);
      3'd3, 3'd4, 3'd5: n = int'(rs_amt);
      default:          n = 0;
    endcase
    case (op)
      3'd0, 3'd3: return rt << n;
      3'd1, 3'd4: return rt >> n;
      3'd2, 3'd5: return 32'($signed(rt) >>> n);
      default:    return rt;
    endcase
  endfunction

  task automatic randomize_inputs();
    bus.op    = 3'($urandom);
    bus.shamt = 5'($urandom);
    bus.rs    = $urandom;
    bus.rt    = $urandom;
  endtask

  // Issue at a negedge; returns at the negedge of the DONE cycle with start low.
  // Start is pulsed randomly (with junk operands) while the shift runs.
  task automatic issue(input logic [2:0] op, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt);
    int n;
    logic [31:0] r;
    exp_t e;
    r = ref_shift(op, sh, rs, rt, n);
    e.res = r;
    e.acc_cyc = cyc + 1;
    e.done_cyc = cyc + n + 1;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op = op;
    bus.shamt = sh;
    bus.rs = rs;
    bus.rt = rt;
    for (int j = 1; j <= n + 1; j++) begin
      @(negedge clk);
      randomize_inputs();
      bus.start = (j <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic idle(input int k);
    bus.start = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic exp_busy;
    exp_t e;
    #1;
    if (!rst) begin
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc_cyc) && (cyc < sb[0].done_cyc);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cyc %0d: got done=1 expected done=0", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          last_result = e.res;
        end
      end else begin
        chk("result_hold", bus.result, last_result);
        if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
          checks++;
          errors++;
          $display("FAIL done_timeout at cyc %0d: got no done expected done at cyc %0d",
                   cyc, sb[0].done_cyc);
          e = sb.pop_front();
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.shamt = 5'd0;
    bus.rs = 32'h0;
    bus.rt = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_result", bus.result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(3'd2, 5'd4, $urandom, 32'h8000_0000);
    idle(2);
    issue(3'd4, 5'($urandom), 32'h0000_0025, 32'hFFFF_FFFF);
    idle(1);
    issue(3'd0, 5'd0, $urandom, 32'h1234_5678);
    idle(1);
    issue(3'd0, 5'd31, $urandom, 32'h0000_0001);
    issue(3'd3, 5'($urandom), {27'($urandom), 5'd1}, 32'h0000_0003);
    idle(2);

    // Asynchronous reset in the middle of an srl by 10.
    begin
      exp_t e;
      e.res = 32'h0;
      e.acc_cyc = cyc + 1;
      e.done_cyc = cyc + 11;
      sb.push_back(e);
      bus.start = 1'b1;
      bus.op = 3'd1;
      bus.shamt = 5'd10;
      bus.rt = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_busy", 32'(bus.busy), 32'h0);
      chk("midreset_done", 32'(bus.done), 32'h0);
      chk("midreset_result", bus.result, 32'h0);
      sb.delete();
      last_result = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
    issue(3'd1, 5'd1, $urandom, 32'h0000_0002);
    idle(1);
    issue(3'd7, 5'($urandom), $urandom, 32'hDEAD_BEEF);
    idle(1);

    // Randomized traffic, half back-to-back.
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom), 5'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit for the CPU's six MIPS shift instructions (sll, srl, sra, sllv, srlv, srav). It shifts one bit position per clock, so no 32-bit barrel shifter sits in the ALU path. The main control FSM issues a start pulse, waits for done, then writes result to the register file. The shift amount is the 5-bit shamt field or rs[4:0], zero-extended to 32 bits to form the cycle counter.

## Interface
- No parameters; data width fixed at 32, amount field fixed at 5.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when the unit is ready (IDLE or DONE).
- op  input  3  0=sll, 1=srl, 2=sra, 3=sllv, 4=srlv, 5=srav; 6 and 7 reserved.
- shamt  input  5  instruction shamt field; used by sll/srl/sra.
- rs  input  32  variable-amount source; only rs[4:0] is used by sllv/srlv/srav.
- rt  input  32  operand to be shifted.
- busy  output  1  high while a shift is in progress (state SHIFT).
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  32  shifted value; held until the next accepted start.

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- Reset values: busy=0, done=0, result=32'h0. Internal data register and counter clear to 0.
- Start acceptance:
  - start is accepted in IDLE or DONE. It is ignored in SHIFT.
  - On accept, latch rt into the data register and latch op.
  - Amount n: shamt for op 0–2, rs[4:0] for op 3–5. n is zero-extended to 32 bits and loaded into the down-counter.
- Transitions on accept:
  - n ≠ 0 → SHIFT.
  - n = 0 → DONE.
  - Reserved op: treated as n = 0 with rt passed through unchanged → DONE.
- SHIFT, each cycle:
  - Shift the data register by one bit and decrement the counter.
  - Shift-in bit: 0 for logical left/right; data[31] for arithmetic right (sign is re-sampled from the register each step, which equals the original sign).
  - When the counter reaches 1 before decrement, the final shift is performed and the next state is DONE.
- DONE:
  - done=1 for exactly one cycle; result takes the data register value on entry to DONE.
  - Without start, go to IDLE next cycle. With start, accept it (back-to-back) and go to SHIFT or DONE per the new n.
- IDLE: hold result and wait.
- Maximum amount is 31, which means 31 SHIFT cycles. The 32-bit counter never exceeds 31.
- Inputs op, shamt, rs and rt may change after acceptance without effect.

## Timing
- Start accepted at rising edge k with amount n:
  - busy is high in cycles k+1 … k+n.
  - done is high in cycle k+n+1.
  - Latency is n+1 cycles; n=0 gives done in cycle k+1 with busy never asserted.
- result is registered and updates in the same cycle done rises. It is stable from then until the edge after the next accepted start's final shift.
- busy and done are never high in the same cycle.
- Asynchronous reset mid-SHIFT: outputs go immediately to their reset values and the in-flight operation is discarded. No done is produced for it.
- Start held high continuously: a new operation is accepted in every DONE cycle. The pulse-train period is n+1 cycles.

## Structure
- Package shift_pkg holds:
  - op encodings (OP_SLL … OP_SRAV);
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - constants DATA_W=32 and AMT_W=5.
- One sub-module, shamt_select: a combinational mux of shamt or rs[4:0] by op, zero-extended to 32 bits. Reserved ops output 0.
- The FSM, down-counter and data register live in shift_sequencer itself.

## Test plan
- sra, rt=32'h8000_0000, shamt=4, start at edge 0 → busy in cycles 1–4, done in cycle 5, result=32'hF800_0000.
- srlv, rs=32'h0000_0025 (amount 5), rt=32'hFFFF_FFFF → done in cycle 6, result=32'h07FF_FFFF; rs[31:5] ignored.
- sll, shamt=0, rt=32'h1234_5678 → done in cycle 1, busy never high, result=32'h1234_5678.
- Two starts back-to-back:
  - sll shamt=31, rt=1 → done in cycle 32, result=32'h8000_0000.
  - start re-asserted in cycle 32 with sllv rs[4:0]=1, rt=3 → done in cycle 34, result=6.
  - start pulsed during SHIFT is ignored.
- rst asserted in cycle 3 of an srl by 10 → busy, done and result read 0 immediately, state is IDLE. A fresh srl by 1 of 32'h2 then gives result=1 with done two cycles after start.
- Reserved op=7, rt=32'hDEAD_BEEF → done in cycle 1, result=32'hDEAD_BEEF.
